// File: rtl/alu_imm_dq_mw_pkg.sv
// alu_imm_dq_mw_pkg: core widths, queue entry type and writeback match helper
package alu_imm_dq_mw_pkg;
  localparam int LOG_PR_COUNT = 7;
  localparam int LOG_PRF_BANK_COUNT = 2;
  localparam int PRF_BANK_COUNT = 1 << LOG_PRF_BANK_COUNT;
  localparam int LOG_ROB_ENTRIES = 7;
  localparam int UPPER_W = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;
  typedef logic [LOG_PR_COUNT-1:0] pr_t;
  typedef logic [LOG_ROB_ENTRIES-1:0] rob_t;
  typedef logic [PRF_BANK_COUNT-1:0][UPPER_W-1:0] wb_upper_t;
  typedef struct packed {
    logic [3:0] op;
    logic [11:0] imm12;
    pr_t A_PR;
    logic A_ready;
    logic A_is_zero;
    pr_t dest_PR;
    rob_t ROB_index;
  } alu_imm_dq_entry_t;
  function automatic logic pr_wakeup(pr_t pr, logic [PRF_BANK_COUNT-1:0] wb_valid, wb_upper_t wb_upper);
    return wb_valid[pr[LOG_PRF_BANK_COUNT-1:0]] && wb_upper[pr[LOG_PRF_BANK_COUNT-1:0]] == pr[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
  endfunction
endpackage

// File: rtl/alu_imm_dq_mw_if.sv
// alu_imm_dq_mw_if: dispatch, writeback, restart and issue-queue enqueue bundle
interface alu_imm_dq_mw_if
  import alu_imm_dq_mw_pkg::*;
#(
  parameter int DISPATCH_WAYS = 4,
  parameter int LAUNCH_WAYS = 2,
  parameter int OCC_W = 4
);
  logic [DISPATCH_WAYS-1:0] dispatch_attempt_by_way;
  logic [DISPATCH_WAYS-1:0] dispatch_valid_by_way;
  logic [DISPATCH_WAYS-1:0][3:0] dispatch_op_by_way;
  logic [DISPATCH_WAYS-1:0][11:0] dispatch_imm12_by_way;
  pr_t [DISPATCH_WAYS-1:0] dispatch_A_PR_by_way;
  logic [DISPATCH_WAYS-1:0] dispatch_A_ready_by_way;
  logic [DISPATCH_WAYS-1:0] dispatch_A_is_zero_by_way;
  pr_t [DISPATCH_WAYS-1:0] dispatch_dest_PR_by_way;
  rob_t [DISPATCH_WAYS-1:0] dispatch_ROB_index_by_way;
  logic [DISPATCH_WAYS-1:0] dispatch_ack_by_way;
  logic [PRF_BANK_COUNT-1:0] WB_bus_valid_by_bank;
  wb_upper_t WB_bus_upper_PR_by_bank;
  logic kill_valid;
  rob_t kill_ROB_index;
  rob_t rob_head_index;
  logic [LAUNCH_WAYS-1:0] iq_enq_valid;
  logic [LAUNCH_WAYS-1:0][3:0] iq_enq_op;
  logic [LAUNCH_WAYS-1:0][11:0] iq_enq_imm12;
  pr_t [LAUNCH_WAYS-1:0] iq_enq_A_PR;
  logic [LAUNCH_WAYS-1:0] iq_enq_A_ready;
  logic [LAUNCH_WAYS-1:0] iq_enq_A_is_zero;
  pr_t [LAUNCH_WAYS-1:0] iq_enq_dest_PR;
  rob_t [LAUNCH_WAYS-1:0] iq_enq_ROB_index;
  logic [LAUNCH_WAYS-1:0] iq_enq_ready;
  logic [OCC_W-1:0] occupancy;
  modport master (
    output dispatch_attempt_by_way, dispatch_valid_by_way, dispatch_op_by_way, dispatch_imm12_by_way,
           dispatch_A_PR_by_way, dispatch_A_ready_by_way, dispatch_A_is_zero_by_way, dispatch_dest_PR_by_way,
           dispatch_ROB_index_by_way, WB_bus_valid_by_bank, WB_bus_upper_PR_by_bank, kill_valid,
           kill_ROB_index, rob_head_index, iq_enq_ready,
    input  dispatch_ack_by_way, iq_enq_valid, iq_enq_op, iq_enq_imm12, iq_enq_A_PR, iq_enq_A_ready,
           iq_enq_A_is_zero, iq_enq_dest_PR, iq_enq_ROB_index, occupancy
  );
  modport slave (
    input  dispatch_attempt_by_way, dispatch_valid_by_way, dispatch_op_by_way, dispatch_imm12_by_way,
           dispatch_A_PR_by_way, dispatch_A_ready_by_way, dispatch_A_is_zero_by_way, dispatch_dest_PR_by_way,
           dispatch_ROB_index_by_way, WB_bus_valid_by_bank, WB_bus_upper_PR_by_bank, kill_valid,
           kill_ROB_index, rob_head_index, iq_enq_ready,
    output dispatch_ack_by_way, iq_enq_valid, iq_enq_op, iq_enq_imm12, iq_enq_A_PR, iq_enq_A_ready,
           iq_enq_A_is_zero, iq_enq_dest_PR, iq_enq_ROB_index, occupancy
  );
endinterface

// File: rtl/alu_imm_dq_mw_rob_age_cmp.sv
// rob_age_cmp: true when idx is at or younger than ref_idx, ages measured from the ROB head
module rob_age_cmp
  import alu_imm_dq_mw_pkg::*;
(
  input  rob_t idx,
  input  rob_t ref_idx,
  input  rob_t head,
  output logic younger_eq
);
  rob_t idx_age, ref_age;
  assign idx_age = idx - head;
  assign ref_age = ref_idx - head;
  assign younger_eq = idx_age >= ref_age;
endmodule

// File: rtl/alu_imm_dq_mw.sv
// alu_imm_dq_mw: in-order shift-compacting multi-wide dispatch queue for the ALU reg-imm issue queue
module alu_imm_dq_mw
  import alu_imm_dq_mw_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int DISPATCH_WAYS = 4,
  parameter int LAUNCH_WAYS = 2
) (
  input logic CLK,
  input logic RST,
  alu_imm_dq_mw_if.slave bus
);
  localparam int OCC_W = $clog2(ENTRIES + 1);
  alu_imm_dq_entry_t [ENTRIES-1:0] ent_q, ent_n, held;
  alu_imm_dq_entry_t [DISPATCH_WAYS-1:0] disp;
  logic [ENTRIES-1:0] valid_q, valid_n, wake, younger;
  logic [OCC_W-1:0] occ_q;
  logic [LAUNCH_WAYS-1:0] launch;
  logic [DISPATCH_WAYS-1:0] ack;
  logic go, run;
  int n_launch, n_att, n_placed, n_valid;
  assign go = ~RST & ~bus.kill_valid;
  for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
    rob_age_cmp u_age (
      .idx(ent_q[i].ROB_index),
      .ref_idx(bus.kill_ROB_index),
      .head(bus.rob_head_index),
      .younger_eq(younger[i])
    );
    assign wake[i] = pr_wakeup(ent_q[i].A_PR, bus.WB_bus_valid_by_bank, bus.WB_bus_upper_PR_by_bank);
  end
  always_comb begin
    held = ent_q;
    for (int i = 0; i < ENTRIES; i++) held[i].A_ready = ent_q[i].A_ready | wake[i];
    launch = '0;
    run = go;
    n_launch = 0;
    for (int k = 0; k < LAUNCH_WAYS; k++) begin
      run = run & valid_q[k] & bus.iq_enq_ready[k];
      launch[k] = run;
      n_launch += run ? 1 : 0;
    end
    // acks see only slots free at the start of the cycle, never those vacated by launch
    ack = '0;
    n_att = 0;
    for (int w = 0; w < DISPATCH_WAYS; w++) begin
      disp[w] = '{op: bus.dispatch_op_by_way[w], imm12: bus.dispatch_imm12_by_way[w],
                  A_PR: bus.dispatch_A_PR_by_way[w],
                  A_ready: bus.dispatch_A_ready_by_way[w] |
                           pr_wakeup(bus.dispatch_A_PR_by_way[w], bus.WB_bus_valid_by_bank, bus.WB_bus_upper_PR_by_bank),
                  A_is_zero: bus.dispatch_A_is_zero_by_way[w], dest_PR: bus.dispatch_dest_PR_by_way[w],
                  ROB_index: bus.dispatch_ROB_index_by_way[w]};
      ack[w] = bus.dispatch_attempt_by_way[w] & go & (n_att < ENTRIES - int'(occ_q));
      n_att += bus.dispatch_attempt_by_way[w] ? 1 : 0;
    end
    ent_n = '0;
    valid_n = '0;
    for (int i = 0; i < ENTRIES; i++)
      for (int s = i; s < ENTRIES; s++)
        if (s == (bus.kill_valid ? i : i + n_launch) && valid_q[s] && !(bus.kill_valid && younger[s])) begin
          ent_n[i] = held[s];
          valid_n[i] = 1'b1;
        end
    // acked bubbles are dropped here so valid entries stay a contiguous prefix
    n_placed = 0;
    for (int w = 0; w < DISPATCH_WAYS; w++)
      if (ack[w] && bus.dispatch_valid_by_way[w]) begin
        for (int i = 0; i < ENTRIES; i++)
          if (i == int'(occ_q) - n_launch + n_placed) begin
            ent_n[i] = disp[w];
            valid_n[i] = 1'b1;
          end
        n_placed++;
      end
    n_valid = 0;
    for (int i = 0; i < ENTRIES; i++) n_valid += valid_n[i] ? 1 : 0;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      ent_q <= '0;
      valid_q <= '0;
      occ_q <= '0;
    end else begin
      ent_q <= ent_n;
      valid_q <= valid_n;
      occ_q <= OCC_W'(n_valid);
    end
  end
  assign bus.dispatch_ack_by_way = ack;
  assign bus.iq_enq_valid = launch;
  assign bus.occupancy = occ_q;
  for (genvar k = 0; k < LAUNCH_WAYS; k++) begin : g_out
    assign bus.iq_enq_op[k] = held[k].op;
    assign bus.iq_enq_imm12[k] = held[k].imm12;
    assign bus.iq_enq_A_PR[k] = held[k].A_PR;
    assign bus.iq_enq_A_ready[k] = held[k].A_ready;
    assign bus.iq_enq_A_is_zero[k] = held[k].A_is_zero;
    assign bus.iq_enq_dest_PR[k] = held[k].dest_PR;
    assign bus.iq_enq_ROB_index[k] = held[k].ROB_index;
  end
endmodule

// File: tb/tb_alu_imm_dq_mw.sv
// tb_alu_imm_dq_mw: directed and randomized checks of alu_imm_dq_mw against a queue model
module tb_alu_imm_dq_mw;
  import alu_imm_dq_mw_pkg::*;
  localparam int ENTRIES = 8, DW = 4, LW = 2, ROB_N = 1 << LOG_ROB_ENTRIES;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  alu_imm_dq_mw_if #(.DISPATCH_WAYS(DW), .LAUNCH_WAYS(LW), .OCC_W($clog2(ENTRIES + 1))) bus ();
  alu_imm_dq_mw #(.ENTRIES(ENTRIES), .DISPATCH_WAYS(DW), .LAUNCH_WAYS(LW)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;
  alu_imm_dq_entry_t q[$];
  int n_chk, n_fail, last_nack;
  rob_t rob_ctr, r;
  logic do_kill;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int age(rob_t x);
    return (int'(x) - int'(bus.rob_head_index) + ROB_N) % ROB_N;
  endfunction
  function automatic alu_imm_dq_entry_t wk(alu_imm_dq_entry_t e);
    int b = int'(e.A_PR) % PRF_BANK_COUNT;
    if (bus.WB_bus_valid_by_bank[b] && int'(bus.WB_bus_upper_PR_by_bank[b]) == int'(e.A_PR) / PRF_BANK_COUNT) e.A_ready = 1'b1;
    return e;
  endfunction
  function automatic alu_imm_dq_entry_t way_entry(int w);
    return '{op: bus.dispatch_op_by_way[w], imm12: bus.dispatch_imm12_by_way[w], A_PR: bus.dispatch_A_PR_by_way[w],
             A_ready: bus.dispatch_A_ready_by_way[w], A_is_zero: bus.dispatch_A_is_zero_by_way[w],
             dest_PR: bus.dispatch_dest_PR_by_way[w], ROB_index: bus.dispatch_ROB_index_by_way[w]};
  endfunction
  function automatic alu_imm_dq_entry_t iq_entry(int k);
    return '{op: bus.iq_enq_op[k], imm12: bus.iq_enq_imm12[k], A_PR: bus.iq_enq_A_PR[k], A_ready: bus.iq_enq_A_ready[k],
             A_is_zero: bus.iq_enq_A_is_zero[k], dest_PR: bus.iq_enq_dest_PR[k], ROB_index: bus.iq_enq_ROB_index[k]};
  endfunction
  task automatic idle();
    bus.dispatch_attempt_by_way = '0;
    bus.dispatch_valid_by_way = '0;
    bus.dispatch_op_by_way = '0;
    bus.dispatch_imm12_by_way = '0;
    bus.dispatch_A_PR_by_way = '0;
    bus.dispatch_A_ready_by_way = '0;
    bus.dispatch_A_is_zero_by_way = '0;
    bus.dispatch_dest_PR_by_way = '0;
    bus.dispatch_ROB_index_by_way = '0;
    bus.WB_bus_valid_by_bank = '0;
    bus.WB_bus_upper_PR_by_bank = '0;
    bus.kill_valid = 1'b0;
    bus.kill_ROB_index = '0;
  endtask
  task automatic put(int w, rob_t rob, pr_t pr, logic rdy, logic v);
    bus.dispatch_attempt_by_way[w] = 1'b1;
    bus.dispatch_valid_by_way[w] = v;
    bus.dispatch_op_by_way[w] = 4'($urandom);
    bus.dispatch_imm12_by_way[w] = 12'($urandom);
    bus.dispatch_A_PR_by_way[w] = pr;
    bus.dispatch_A_ready_by_way[w] = rdy;
    bus.dispatch_A_is_zero_by_way[w] = 1'($urandom);
    bus.dispatch_dest_PR_by_way[w] = pr_t'($urandom);
    bus.dispatch_ROB_index_by_way[w] = rob;
  endtask
  task automatic step();
    alu_imm_dq_entry_t nq[$];
    logic [DW-1:0] e_ack;
    logic [LW-1:0] e_val;
    int nl, natt;
    logic rst_now;
    e_ack = '0;
    e_val = '0;
    nl = 0;
    natt = 0;
    #1;
    rst_now = RST;
    if (!rst_now) begin
      if (bus.kill_valid) begin
        foreach (q[i]) if (age(q[i].ROB_index) < age(bus.kill_ROB_index)) nq.push_back(wk(q[i]));
      end else begin
        while (nl < LW && nl < q.size() && bus.iq_enq_ready[nl]) nl++;
        for (int k = 0; k < nl; k++) begin
          e_val[k] = 1'b1;
          check("iq_payload", 64'(iq_entry(k)), 64'(wk(q[k])));
        end
        for (int i = nl; i < q.size(); i++) nq.push_back(wk(q[i]));
        for (int w = 0; w < DW; w++)
          if (bus.dispatch_attempt_by_way[w]) begin
            if (natt < ENTRIES - q.size()) begin
              e_ack[w] = 1'b1;
              if (bus.dispatch_valid_by_way[w]) nq.push_back(wk(way_entry(w)));
            end
            natt++;
          end
      end
    end
    last_nack = $countones(e_ack);
    check("dispatch_ack", 64'(bus.dispatch_ack_by_way), 64'(e_ack));
    check("iq_enq_valid", 64'(bus.iq_enq_valid), 64'(e_val));
    @(posedge CLK);
    if (rst_now) q.delete();
    else q = nq;
    @(negedge CLK);
    check("occupancy", 64'(bus.occupancy), 64'(q.size()));
  endtask
  initial begin
    n_chk = 0;
    n_fail = 0;
    rob_ctr = '0;
    bus.rob_head_index = '0;
    bus.iq_enq_ready = '0;
    idle();
    @(negedge CLK);
    step();
    step();
    RST = 1'b0;
    for (int w = 0; w < DW; w++) put(w, rob_t'(w), pr_t'(w), 1'b1, 1'b1);
    bus.iq_enq_ready = 2'b11;
    step();
    idle();
    step();
    step();
    bus.iq_enq_ready = '0;
    for (int s = 0; s < 3; s++) begin
      idle();
      for (int w = 0; w < DW; w++) put(w, rob_t'(4 + 4 * s + w), pr_t'(w + 8), 1'b1, 1'b1);
      step();
    end
    check("full_occ", 64'(bus.occupancy), 64'(8));
    idle();
    bus.iq_enq_ready = 2'b01;
    step();
    bus.iq_enq_ready = 2'b10;
    step();
    bus.iq_enq_ready = 2'b11;
    for (int s = 0; s < 4; s++) step();
    bus.iq_enq_ready = '0;
    put(0, 7'd20, 7'h25, 1'b0, 1'b1);
    step();
    idle();
    bus.WB_bus_valid_by_bank[1] = 1'b1;
    bus.WB_bus_upper_PR_by_bank[1] = 5'h09;
    put(0, 7'd21, 7'h25, 1'b0, 1'b1);
    step();
    idle();
    bus.iq_enq_ready = 2'b11;
    check("wake_held", 64'(bus.iq_enq_A_ready), 64'(2'b11));
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    bus.iq_enq_ready = '0;
    bus.rob_head_index = rob_t'(ROB_N - 2);
    for (int w = 0; w < DW; w++) put(w, rob_t'(ROB_N - 2 + w), pr_t'(w), 1'b1, 1'b1);
    step();
    idle();
    bus.kill_valid = 1'b1;
    bus.kill_ROB_index = '0;
    bus.iq_enq_ready = 2'b11;
    put(0, 7'd2, 7'd3, 1'b1, 1'b1);
    step();
    check("kill_occ", 64'(bus.occupancy), 64'(2));
    idle();
    step();
    bus.rob_head_index = '0;
    bus.iq_enq_ready = '0;
    for (int s = 0; s < 2; s++) begin
      idle();
      for (int w = 0; w < DW; w++) put(w, rob_t'(10 + 4 * s + w), pr_t'(w), 1'b1, 1'b1);
      step();
    end
    idle();
    bus.iq_enq_ready = 2'b11;
    RST = 1'b1;
    step();
    RST = 1'b0;
    step();
    put(0, 7'd30, 7'd5, 1'b1, 1'b1);
    step();
    idle();
    check("post_rst_launch", 64'(bus.iq_enq_ROB_index[0]), 64'(30));
    step();
    rob_ctr = 7'd40;
    for (int c = 0; c < 2000; c++) begin
      idle();
      bus.rob_head_index = q.size() > 0 ? q[0].ROB_index : rob_ctr;
      bus.iq_enq_ready = LW'($urandom);
      bus.WB_bus_valid_by_bank = PRF_BANK_COUNT'($urandom);
      for (int b = 0; b < PRF_BANK_COUNT; b++) bus.WB_bus_upper_PR_by_bank[b] = UPPER_W'($urandom_range(0, 3));
      r = rob_ctr;
      for (int w = 0; w < DW; w++)
        if ($urandom_range(0, 3) != 0) begin
          put(w, r, pr_t'($urandom_range(0, 15)), 1'($urandom), $urandom_range(0, 4) != 0);
          r = r + 1'b1;
        end
      do_kill = $urandom_range(0, 15) == 0;
      if (do_kill) begin
        bus.kill_valid = 1'b1;
        bus.kill_ROB_index = bus.rob_head_index + rob_t'($urandom_range(0, age(rob_ctr)));
      end
      RST = $urandom_range(0, 63) == 0;
      step();
      if (RST) RST = 1'b0;
      else if (do_kill) rob_ctr = bus.kill_ROB_index;
      else rob_ctr = rob_ctr + rob_t'(last_nack);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
